// File: rtl/uart_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_pkg
// Brief    : Shared types and constants for the UART packet controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_alu_pkg;

    // Packet parser states
    typedef enum logic [2:0] {
        S_OPCODE  = 3'd0,
        S_RSV     = 3'd1,
        S_LEN_LO  = 3'd2,
        S_LEN_HI  = 3'd3,
        S_PAYLOAD = 3'd4,
        S_DRAIN   = 3'd5,
        S_RESULT  = 3'd6
    } state_t;

    // Decoded opcode class, latched once per packet
    typedef enum logic [1:0] {
        K_ECHO = 2'd0,
        K_ADD  = 2'd1,
        K_XOR  = 2'd2,
        K_UNK  = 2'd3
    } op_kind_t;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD   = 8'hA0;
    localparam logic [7:0] OP_XOR   = 8'hA1;
    localparam logic [7:0] ERR_BYTE = 8'hEE;
    localparam int         HDR_BYTES = 4;

    function automatic op_kind_t decode_op(input logic [7:0] opcode);
        case (opcode)
            OP_ECHO: decode_op = K_ECHO;
            OP_ADD:  decode_op = K_ADD;
            OP_XOR:  decode_op = K_XOR;
            default: decode_op = K_UNK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_alu_acc.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_acc
// Brief    : Assembles payload bytes LSB-first into 32-bit operands and folds
//            each operand into an add or xor accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_acc
    import uart_alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        last,
    input  op_kind_t    op,
    input  logic        clear,
    output logic [31:0] result
);

    logic [31:0] r_acc;
    logic [31:0] r_opnd;
    logic [1:0]  r_idx;
    logic [31:0] w_opnd;

    // Merge the incoming byte into its lane; unfilled lanes stay zero so a
    // trailing partial operand is zero-extended for free.
    assign w_opnd = r_opnd | (32'(byte_data) << {r_idx, 3'b000});
    assign result = r_acc;

    // Operand assembly and fold on the 4th byte or the final payload byte
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_idx  <= '0;
        end else if (byte_valid) begin
            if (r_idx == 2'd3 || last) begin
                r_acc  <= (op == K_XOR) ? (r_acc ^ w_opnd) : (r_acc + w_opnd);
                r_opnd <= '0;
                r_idx  <= '0;
            end else begin
                r_opnd <= w_opnd;
                r_idx  <= r_idx + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_ctrl
// Brief    : Packet controller between UART RX and TX streams. Parses framed
//            command packets and performs echo, 32-bit add or 32-bit xor.
//            Optional macro ALU_CTRL_ERR_RESP_EN: send 0xEE after an unknown
//            opcode packet and after a timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int LEN_WIDTH      = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       abort_o
);

    state_t                 r_state;
    state_t                 w_next;
    op_kind_t               r_kind;
    logic [7:0]             r_len_lo;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [2:0]             r_res_cnt;
    logic                   r_tx_valid;
    logic [7:0]             r_tx_data;
    logic                   r_abort;

    logic                   w_rx_ready;
    logic                   w_rx_acc;
    logic                   w_tx_hs;
    logic                   w_tx_free;
    logic                   w_tx_load;
    logic [7:0]             w_tx_load_data;
    logic                   w_acc_valid;
    logic                   w_acc_last;
    logic                   w_acc_clear;
    logic                   w_tmo_run;
    logic                   w_tmo_fire;
    logic [LEN_WIDTH-1:0]   w_len;
    logic                   w_len_le_hdr;
    logic                   w_last_byte;
    logic [31:0]            w_result;
    logic [7:0]             w_res_byte;

    assign w_rx_acc     = rx_valid_i && w_rx_ready;
    assign w_tx_hs      = r_tx_valid && tx_ready_i;
    assign w_tx_free    = !r_tx_valid || tx_ready_i;
    assign w_len        = LEN_WIDTH'({rx_data_i, r_len_lo});
    assign w_len_le_hdr = (w_len <= LEN_WIDTH'(HDR_BYTES));
    assign w_last_byte  = (r_remaining == LEN_WIDTH'(1));
    assign w_res_byte   = w_result[{r_res_cnt[1:0], 3'b000} +: 8];

    assign rx_ready_o = w_rx_ready;
    assign tx_valid_o = r_tx_valid;
    assign tx_data_o  = r_tx_data;
    assign busy_o     = (r_state != S_OPCODE);
    assign abort_o    = r_abort;

    // Timer is frozen while idle, while sending a result, and while an echo
    // byte is stalled by TX back-pressure.
    assign w_tmo_run = (r_state != S_OPCODE) && (r_state != S_RESULT) &&
                       !(r_state == S_PAYLOAD && r_kind == K_ECHO &&
                         r_tx_valid && !tx_ready_i);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo_on
            localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            logic [TMO_W-1:0] r_tmo_cnt;

            // An accepted byte in the same cycle always beats the timeout
            assign w_tmo_fire = w_tmo_run && !w_rx_acc &&
                                (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

            // Idle-gap counter, cleared by every accepted RX byte
            always_ff @(posedge clk_i) begin
                if (rst_i || w_rx_acc || !w_tmo_run || w_tmo_fire) begin
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
            end
        end else begin : g_tmo_off
            assign w_tmo_fire = 1'b0;
        end
    endgenerate

    // Next-state and per-state handshake decode
    always_comb begin
        w_next         = r_state;
        w_rx_ready     = 1'b1;
        w_tx_load      = 1'b0;
        w_tx_load_data = ERR_BYTE;
        w_acc_valid    = 1'b0;
        w_acc_last     = 1'b0;
        w_acc_clear    = 1'b0;
        case (r_state)
            S_OPCODE: begin
                if (w_rx_acc) begin
                    w_next      = S_RSV;
                    w_acc_clear = 1'b1;
                end
            end
            S_RSV: begin
                if (w_rx_acc) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_rx_acc) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_rx_acc) begin
                    if (w_len_le_hdr) begin
                        if (r_kind == K_ADD || r_kind == K_XOR) begin
                            w_next = S_RESULT;
                        end else begin
                            w_next = S_OPCODE;
`ifdef ALU_CTRL_ERR_RESP_EN
                            w_tx_load = (r_kind == K_UNK);
`endif
                        end
                    end else begin
                        w_next = (r_kind == K_UNK) ? S_DRAIN : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (r_kind == K_ECHO) begin
                    if (r_remaining == '0) begin
                        // Last byte is in the output register; wait for TX
                        w_rx_ready = 1'b0;
                        if (w_tx_free) w_next = S_OPCODE;
                    end else begin
                        w_rx_ready     = w_tx_free;
                        w_tx_load      = w_rx_acc;
                        w_tx_load_data = rx_data_i;
                    end
                end else begin
                    w_acc_valid = w_rx_acc;
                    w_acc_last  = w_last_byte;
                    if (w_rx_acc && w_last_byte) w_next = S_RESULT;
                end
            end
            S_DRAIN: begin
                if (w_rx_acc && w_last_byte) begin
                    w_next = S_OPCODE;
`ifdef ALU_CTRL_ERR_RESP_EN
                    w_tx_load = 1'b1;
`endif
                end
            end
            S_RESULT: begin
                w_rx_ready = 1'b0;
                if (r_res_cnt != 3'd4 && w_tx_free) begin
                    w_tx_load      = 1'b1;
                    w_tx_load_data = w_res_byte;
                end
                if (r_res_cnt == 3'd4 && w_tx_hs) w_next = S_OPCODE;
            end
            default: w_next = S_OPCODE;
        endcase
    end

    // State register; a timeout abort overrides the normal transition
    always_ff @(posedge clk_i) begin
        if (rst_i || w_tmo_fire) begin
            r_state <= S_OPCODE;
        end else begin
            r_state <= w_next;
        end
    end

    // Header fields, payload byte counter and result byte index
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_kind      <= K_ECHO;
            r_len_lo    <= '0;
            r_remaining <= '0;
            r_res_cnt   <= '0;
        end else begin
            if (r_state == S_OPCODE && w_rx_acc) r_kind <= decode_op(rx_data_i);
            if (r_state == S_LEN_LO && w_rx_acc) r_len_lo <= rx_data_i;
            if (r_state == S_LEN_HI && w_rx_acc) begin
                r_remaining <= w_len_le_hdr ? '0 : (w_len - LEN_WIDTH'(HDR_BYTES));
            end else if ((r_state == S_PAYLOAD || r_state == S_DRAIN) && w_rx_acc) begin
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
            if (r_state != S_RESULT) begin
                r_res_cnt <= '0;
            end else if (w_tx_load) begin
                r_res_cnt <= r_res_cnt + 3'd1;
            end
        end
    end

    // One-byte TX output register; data only changes when the slot is free
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
`ifdef ALU_CTRL_ERR_RESP_EN
        end else if (w_tmo_fire) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= ERR_BYTE;
`endif
        end else if (w_tx_load) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_tx_load_data;
        end else if (w_tx_hs) begin
            r_tx_valid <= 1'b0;
        end
    end

    // Abort pulse, one cycle wide
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_tmo_fire;
        end
    end

    uart_alu_acc u_acc (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .byte_data  (rx_data_i),
        .byte_valid (w_acc_valid),
        .last       (w_acc_last),
        .op         (r_kind),
        .clear      (w_acc_clear || w_tmo_fire),
        .result     (w_result)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_alu_ctrl
// Brief    : Scoreboard bench for uart_alu_ctrl: directed packets push their
//            expected TX bytes; a monitor pops and compares on each TX beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_alu_ctrl;

    localparam int TMO = 100;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       abort;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_alu_ctrl #(.TIMEOUT_CYCLES(TMO), .LEN_WIDTH(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .abort_o    (abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every TX beat against the scoreboard, and check that
    // data holds steady while stalled.
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && tx_valid) begin
            if (stall_prev) check("tx_stable", tx_data, stall_data);
            if (tx_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected: got %02h, expected no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_data, e);
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                stall_data = tx_data;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic ok;
        rx_data  = b;
        rx_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL rx_accept: byte %02h not accepted, required within 200 cycles", b);
        end
    endtask

    task automatic send_pkt(input bq_t p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic expect_bytes(input bq_t e);
        foreach (e[i]) exp_q.push_back(e[i]);
    endtask

    // Wait for all expected bytes; optionally require busy low right at the
    // edge that took the last byte.
    task automatic wait_drain(input string name, input bit busy_at_last);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (exp_q.size() != 0 && n < 500);
        check({name, "_drained"}, exp_q.size(), 0);
        if (!busy_at_last) begin
            n = 0;
            while ((busy || tx_valid) && n < 500) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        check({name, "_idle"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_abort", abort, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_rx_ready", rx_ready, 1);

        // Echo
        expect_bytes('{8'h41, 8'h42, 8'h43});
        send_pkt('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43});
        wait_drain("echo", 1'b1);

        // Echo under 20 cycles of TX back-pressure
        expect_bytes('{8'h61, 8'h62, 8'h63, 8'h64});
        tx_ready = 1'b0;
        fork
            send_pkt('{8'hEC, 8'h00, 8'h08, 8'h00, 8'h61, 8'h62, 8'h63, 8'h64});
            begin
                repeat (20) @(posedge clk);
                #1;
                tx_ready = 1'b1;
            end
        join
        wait_drain("echo_bp", 1'b1);

        // Add with 32-bit wrap: FFFFFFFF + 2 = 1
        expect_bytes('{8'h01, 8'h00, 8'h00, 8'h00});
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                   8'h02, 8'h00, 8'h00, 8'h00});
        wait_drain("add_wrap", 1'b1);

        // Xor with trailing partial operand: 0F0F0F0F ^ 0000F0F0 = 0F0FFFFF
        expect_bytes('{8'hFF, 8'hFF, 8'h0F, 8'h0F});
        send_pkt('{8'hA1, 8'h00, 8'h0A, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'hF0, 8'hF0});
        wait_drain("xor_partial", 1'b1);

        // Empty add payload
        expect_bytes('{8'h00, 8'h00, 8'h00, 8'h00});
        send_pkt('{8'hA0, 8'h00, 8'h04, 8'h00});
        wait_drain("add_empty", 1'b1);

        // Unknown opcode is drained
`ifdef ALU_CTRL_ERR_RESP_EN
        expect_bytes('{8'hEE});
`endif
        send_pkt('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
        wait_drain("unknown", 1'b0);

        // Next packet after unknown: xor of a single operand
        expect_bytes('{8'h01, 8'h02, 8'h03, 8'h04});
        send_pkt('{8'hA1, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
        wait_drain("after_unknown", 1'b1);

        // Timeout inside an add payload
`ifdef ALU_CTRL_ERR_RESP_EN
        expect_bytes('{8'hEE});
`endif
        send_pkt('{8'hA0, 8'h00, 8'h08, 8'h00, 8'h01});
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #2;
            n++;
            seen = abort;
        end
        check("tmo_abort_seen", seen, 1);
        check("tmo_latency_ok", (n >= 95 && n <= 105), 1);
        check("tmo_busy", busy, 0);
        @(posedge clk);
        #2;
        check("tmo_pulse_width", abort, 0);
        wait_drain("tmo", 1'b0);

        // Echo after abort
        expect_bytes('{8'h5A});
        send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A});
        wait_drain("echo_after_tmo", 1'b1);

        // Reset while a result byte is stalled; nothing is expected from it
        tx_ready = 1'b0;
        send_pkt('{8'hA0, 8'h00, 8'h04, 8'h00});
        repeat (3) @(posedge clk);
        #2;
        check("result_rx_ready", rx_ready, 0);
        check("result_busy", busy, 1);
        check("result_tx_valid", tx_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        tx_ready = 1'b1;

        // Fresh packet after reset: 0x10 + 0x20 = 0x30
        expect_bytes('{8'h30, 8'h00, 8'h00, 8'h00});
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
                   8'h20, 8'h00, 8'h00, 8'h00});
        wait_drain("after_rst", 1'b1);

        repeat (5) @(posedge clk);
        #2;
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
